// File: rtl/simon_mmio_pkg.sv
// Shared MMIO constants, colour codes and sequencer state encoding for the Simon
// peripheral decoders.
package simon_mmio_pkg;

  localparam logic [11:0] ADDR_PUSH   = 12'd12;
  localparam logic [11:0] ADDR_CTRL   = 12'd13;
  localparam logic [11:0] ADDR_STATUS = 12'd14;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;

  localparam int unsigned STAT_COUNT_LSB = 0;
  localparam int unsigned STAT_BUSY_BIT  = 8;
  localparam int unsigned STAT_OVF_BIT   = 9;
  localparam int unsigned STAT_IDX_LSB   = 16;

  typedef enum logic [1:0] {
    COL_RED    = 2'b00,
    COL_BLUE   = 2'b01,
    COL_GREEN  = 2'b10,
    COL_YELLOW = 2'b11
  } colour_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ON_CMD,
    ST_ON_WAIT,
    ST_OFF_CMD,
    ST_GAP_WAIT,
    ST_FIN,
    ST_ABORT
  } pp_state_t;

  // Assemble the status word; unused bits read as zero.
  function automatic logic [31:0] pack_status(input logic [5:0] idx, input logic ovf,
                                              input logic busy, input logic [5:0] count);
    logic [31:0] s;
    s = '0;
    s[STAT_COUNT_LSB +: 6] = count;
    s[STAT_BUSY_BIT]       = busy;
    s[STAT_OVF_BIT]        = ovf;
    s[STAT_IDX_LSB +: 6]   = idx;
    return s;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Shared down-counter for the on and gap wait states; expires on the last cycle of
// the loaded interval.
module step_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expire_c = (r_cnt == W'(1));

endmodule

// File: rtl/pattern_player.sv
// MMIO sequencer that replays a stored colour pattern as LED/tone command strobes
// with fixed on and gap timing.
module pattern_player
  import simon_mmio_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ON_CYCLES  = 25_000_000,
  parameter int unsigned GAP_CYCLES = 12_500_000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_wren,
  input  logic [11:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_status_hit,
  output logic [31:0] o_status_data,
  output logic        o_led_flash,
  output logic [1:0]  o_led_color,
  output logic        o_led_on,
  output logic        o_tone_play,
  output logic [2:0]  o_tone_color,
  output logic        o_tone_on,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = $clog2(MAXC + 1);

  pp_state_t     r_state;
  colour_t       r_buf [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_idx;
  logic          r_ovf;
  logic          r_strobe;
  logic          r_on;
  colour_t       r_color;
  logic          r_busy;
  logic          r_done;

  logic          w_push;
  logic          w_ctrl;
  logic          w_clear;
  logic          w_start;
  logic          w_push_ok;
  logic [CW-1:0] w_idx_inc;
  colour_t       w_col_cur;
  colour_t       w_col_nxt;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_expire;
  logic          w_unused;

  assign w_push    = i_wren && (i_addr == ADDR_PUSH);
  assign w_ctrl    = i_wren && (i_addr == ADDR_CTRL);
  assign w_clear   = w_ctrl && i_wdata[CTRL_CLEAR_BIT];
  assign w_start   = w_ctrl && i_wdata[CTRL_START_BIT];
  assign w_push_ok = w_push && (r_state == ST_IDLE) && (r_count < CW'(DEPTH));
  assign w_idx_inc = r_idx + CW'(1);
  assign w_col_cur = r_buf[r_idx[AW-1:0]];
  assign w_col_nxt = r_buf[w_idx_inc[AW-1:0]];
  assign w_unused  = ^i_wdata[31:2];

  // Timer is reloaded from the one-cycle command states preceding each wait.
  assign w_load     = (r_state == ST_ON_CMD) || (r_state == ST_OFF_CMD);
  assign w_load_val = (r_state == ST_ON_CMD) ? TW'(ON_CYCLES) : TW'(GAP_CYCLES);

  step_timer #(.W(TW)) u_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expire_c (w_expire)
  );

  // Pattern storage has no reset; slots beyond count are never read.
  always_ff @(posedge i_clock) begin
    if (w_push_ok) begin
      r_buf[r_count[AW-1:0]] <= colour_t'(i_wdata[1:0]);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_idx    <= '0;
      r_ovf    <= 1'b0;
      r_strobe <= 1'b0;
      r_on     <= 1'b0;
      r_color  <= COL_RED;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_clear) begin
          r_count <= '0;
          r_idx   <= '0;
          r_ovf   <= 1'b0;
        end else if (w_start && (r_count != '0)) begin
          r_idx    <= '0;
          r_state  <= ST_ON_CMD;
          r_busy   <= 1'b1;
          r_strobe <= 1'b1;
          r_on     <= 1'b1;
          r_color  <= r_buf[0];
        end else if (w_push) begin
          if (r_count < CW'(DEPTH)) begin
            r_count <= r_count + CW'(1);
          end else begin
            r_ovf <= 1'b1;
          end
        end
      end else if (w_clear && (r_state != ST_ABORT)) begin
        r_state  <= ST_ABORT;
        r_strobe <= 1'b1;
        r_on     <= 1'b0;
        r_color  <= w_col_cur;
      end else begin
        if (w_push) begin
          r_ovf <= 1'b1;
        end
        case (r_state)
          ST_ON_CMD:  r_state <= ST_ON_WAIT;
          ST_ON_WAIT: begin
            if (w_expire) begin
              r_state  <= ST_OFF_CMD;
              r_strobe <= 1'b1;
              r_on     <= 1'b0;
              r_color  <= w_col_cur;
            end
          end
          ST_OFF_CMD: r_state <= ST_GAP_WAIT;
          ST_GAP_WAIT: begin
            if (w_expire) begin
              r_idx <= w_idx_inc;
              if (w_idx_inc == r_count) begin
                r_state <= ST_FIN;
                r_done  <= 1'b1;
              end else begin
                r_state  <= ST_ON_CMD;
                r_strobe <= 1'b1;
                r_on     <= 1'b1;
                r_color  <= w_col_nxt;
              end
            end
          end
          ST_FIN: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          ST_ABORT: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_status_hit  = (i_addr == ADDR_STATUS);
  assign o_status_data = pack_status(6'(r_idx), r_ovf, r_busy, 6'(r_count));
  assign o_led_flash   = r_strobe;
  assign o_tone_play   = r_strobe;
  assign o_led_on      = r_on;
  assign o_tone_on     = r_on;
  assign o_led_color   = r_color;
  assign o_tone_color  = {1'b0, r_color};
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule
